// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state type and operand widths for the GCD scheduler
package gcd_pkg;
    typedef enum logic [1:0] {eIDLE, eISSUE, eWAIT, eRETURN} state_e;
    localparam int DATA_W = 64;
    localparam int HALF_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);
    // Scan from farthest offset down so the nearest requester to ptr wins; IDX_W math wraps.
    always_comb begin
        idx = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[ptr + IDX_W'(i)]) idx = ptr + IDX_W'(i);
        gnt = (|req) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/gcd_rr_sched.sv
// gcd_rr_sched: round-robin sharing of one non-pipelined GCD engine among NUM_REQ requesters
module gcd_rr_sched
    import gcd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_v_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        resp_v_o,
    output logic [DATA_W-1:0]         resp_data_o,
    input  logic [NUM_REQ-1:0]        resp_yumi_i,
    output logic [DATA_W-1:0]         eng_data_o,
    output logic                      eng_v_o,
    input  logic                      eng_ready_i,
    input  logic [DATA_W-1:0]         eng_data_i,
    input  logic                      eng_v_i,
    output logic                      eng_yumi_o,
    output logic [CNT_W-1:0]          done_cnt_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_e             state;
    logic [IDX_W-1:0]   ptr, tag, gidx;
    logic [NUM_REQ-1:0] gnt;
    logic [DATA_W-1:0]  opnd, res;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(req_v_i),
        .ptr(ptr),
        .gnt(gnt),
        .idx(gidx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= eIDLE;
            ptr        <= '0;
            tag        <= '0;
            opnd       <= '0;
            res        <= '0;
            done_cnt_o <= '0;
        end else begin
            case (state)
                eIDLE: if (|req_v_i) begin
                    opnd  <= req_data_i[gidx*DATA_W +: DATA_W];
                    tag   <= gidx;
                    ptr   <= gidx + 1'b1;
                    state <= eISSUE;
                end
                eISSUE: if (eng_ready_i) state <= eWAIT;
                eWAIT: if (eng_v_i) begin
                    res   <= eng_data_i;
                    state <= eRETURN;
                end
                eRETURN: if (resp_yumi_i[tag]) begin
                    done_cnt_o <= done_cnt_o + 1'b1;
                    state      <= eIDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state == eIDLE) ? gnt : '0;
    assign eng_v_o     = state == eISSUE;
    assign eng_data_o  = opnd;
    assign eng_yumi_o  = (state == eWAIT) & eng_v_i;
    assign resp_v_o    = (state == eRETURN) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << tag : '0;
    assign resp_data_o = res;
endmodule

// File: tb/tb_gcd_rr_sched.sv
// tb_gcd_rr_sched: directed checks of the GCD scheduler against a behavioural GCD engine
module tb_gcd_rr_sched;
    import gcd_pkg::*;

    logic          clk = 0;
    logic          reset_i = 1;
    logic [3:0]    req_v = '0, req_ready, resp_v, resp_yumi = '0;
    logic [255:0]  req_data = '0;
    logic [63:0]   resp_data, eng_data_o, eng_data_i;
    logic          eng_v_o, eng_ready_i, eng_v_i, eng_yumi_o;
    logic [3:0]    done_cnt, exp_cnt = '0;
    logic          busy, stall = 0;
    int            lat = 0, cnt;
    int            n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    gcd_rr_sched #(.NUM_REQ(4), .CNT_W(4)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v), .req_data_i(req_data), .req_ready_o(req_ready),
        .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_yumi_i(resp_yumi),
        .eng_data_o(eng_data_o), .eng_v_o(eng_v_o), .eng_ready_i(eng_ready_i),
        .eng_data_i(eng_data_i), .eng_v_i(eng_v_i), .eng_yumi_o(eng_yumi_o),
        .done_cnt_o(done_cnt)
    );

    function automatic logic [63:0] gcd(input logic [63:0] d);
        logic [HALF_W-1:0] a = d[63:32], b = d[31:0], t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return {32'b0, a};
    endfunction

    // Engine: accepts when idle, answers after lat extra cycles, holds result until yumi.
    assign eng_ready_i = !busy && !stall;
    always @(posedge clk) begin
        if (reset_i) begin
            busy <= 0; eng_v_i <= 0; cnt <= 0; eng_data_i <= '0;
        end else if (!busy) begin
            if (eng_v_o && eng_ready_i) begin
                busy <= 1; cnt <= lat; eng_data_i <= gcd(eng_data_o);
            end
        end else if (!eng_v_i) begin
            if (cnt == 0) eng_v_i <= 1;
            else cnt <= cnt - 1;
        end else if (eng_yumi_o) begin
            eng_v_i <= 0; busy <= 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (resp_v == 0 && n < 100) begin
            tick();
            n++;
        end
        chk("resp_seen", 64'(resp_v != 0), 64'd1);
    endtask

    task automatic consume(input int r);
        resp_yumi = 4'b1 << r;
        tick();
        resp_yumi = '0;
        exp_cnt++;
        #1;
        chk("done_cnt", 64'(done_cnt), 64'(exp_cnt));
        chk("resp_v_clear", 64'(resp_v), 64'd0);
    endtask

    task automatic do_job(input int r, input logic [31:0] a, b, input logic [63:0] exp);
        req_v = 4'b1 << r;
        req_data[r*64 +: 64] = {a, b};
        #1;
        chk("grant", 64'(req_ready), 64'(4'b1 << r));
        tick();
        req_v = '0;
        #1;
        chk("grant_one_cycle", 64'(req_ready), 64'd0);
        wait_resp();
        chk("resp_v", 64'(resp_v), 64'(4'b1 << r));
        chk("resp_data", resp_data, exp);
        consume(r);
    endtask

    task automatic do_reset();
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
        exp_cnt = '0;
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_v", 64'(resp_v), 64'd0);
        chk("rst_eng_v", 64'(eng_v_o), 64'd0);
        chk("rst_eng_yumi", 64'(eng_yumi_o), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);

        // Single job from requester 1
        do_job(1, 32'd48, 32'd18, 64'd6);

        // All four requesting after reset: grants 0,1,2,3
        do_reset();
        req_data = {32'd17, 32'd5, 32'd100, 32'd75, 32'd35, 32'd21, 32'd12, 32'd8};
        req_v = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            logic [63:0] exps [4] = '{64'd4, 64'd7, 64'd25, 64'd1};
            #1;
            chk("rr_grant", 64'(req_ready), 64'(4'b1 << k));
            tick();
            req_v[k] = 0;
            wait_resp();
            chk("rr_resp_v", 64'(resp_v), 64'(4'b1 << k));
            chk("rr_resp_data", resp_data, exps[k]);
            consume(k);
        end

        // Engine stall while issuing
        stall = 1;
        req_v = 4'b0001;
        req_data[63:0] = {32'd9, 32'd6};
        tick();
        req_v = '0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_eng_v", 64'(eng_v_o), 64'd1);
            chk("stall_eng_data", eng_data_o, {32'd9, 32'd6});
            tick();
        end
        stall = 0;
        wait_resp();
        chk("stall_resp_data", resp_data, 64'd3);

        // Late consumer with wrong-bit yumi and a pending requester
        req_v = 4'b0010;
        req_data[127:64] = {32'd48, 32'd18};
        resp_yumi = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("late_resp_v", 64'(resp_v), 64'd1);
            chk("late_resp_data", resp_data, 64'd3);
            chk("late_no_grant", 64'(req_ready), 64'd0);
        end
        resp_yumi = '0;
        consume(0);
        chk("late_next_grant", 64'(req_ready), 64'b0010);
        tick();
        req_v = '0;
        wait_resp();
        chk("late_job2_data", resp_data, 64'd6);
        consume(1);

        // Reset while waiting on the engine
        lat = 20;
        req_v = 4'b0100;
        req_data[191:128] = {32'd10, 32'd4};
        tick();
        req_v = '0;
        tick();
        tick();
        chk("wait_state_eng_v", 64'(eng_v_o), 64'd0);
        reset_i = 1;
        tick();
        reset_i = 0;
        exp_cnt = '0;
        #1;
        chk("mid_rst_strobes", {req_ready, resp_v, 6'(eng_v_o), 6'(eng_yumi_o)}, 64'd0);
        chk("mid_rst_done_cnt", 64'(done_cnt), 64'd0);
        repeat (25) tick();
        chk("abandoned_no_resp", 64'(resp_v), 64'd0);
        lat = 0;
        do_job(0, 32'd7, 32'd0, 64'd7);

        // 16 more jobs: counter wraps 15 -> 0 -> 1
        for (int k = 0; k < 16; k++)
            do_job(k % 4, 32'(6 * (k + 1)), 32'(4 * (k + 1)), 64'(2 * (k + 1)));
        chk("wrap_done_cnt", 64'(done_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
